// File: rtl/mips_pkg.sv
// Shared constants, fetch FSM encoding and instruction field positions
// for the fetch stage and its IF/ID register.
package mips_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between fetch and imem.
interface fetch_stage_if;
    import mips_pkg::*;

    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, output addr, input rdata, input ready);
    modport slave  (input req, input addr, output rdata, output ready);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, write enable and a one-entry
// hold buffer for responses that arrive while IF/ID is stalled.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        if_write,
    input  logic        resp_valid,
    input  logic [31:0] resp_instr,
    input  logic [31:0] resp_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid,
    output logic        hold_valid
);

    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic        direct;

    assign direct = resp_valid && if_write && !hold_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr      <= NOP_INSTR;
            pc4        <= '0;
            valid      <= 1'b0;
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc4   <= '0;
        end else if (flush) begin
            instr      <= NOP_INSTR;
            valid      <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (if_write) begin
                if (hold_valid) begin
                    instr      <= hold_instr;
                    pc4        <= hold_pc4;
                    valid      <= 1'b1;
                    hold_valid <= 1'b0;
                end else if (resp_valid) begin
                    instr <= resp_instr;
                    pc4   <= resp_pc4;
                    valid <= 1'b1;
                end else begin
                    instr <= NOP_INSTR;
                    valid <= 1'b0;
                end
            end
            // A response IF/ID cannot take right now parks here.
            if (resp_valid && !direct) begin
                hold_instr <= resp_instr;
                hold_pc4   <= resp_pc4;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, variable-latency imem handshake FSM, branch
// redirect/flush, feeding the IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_write,
    input  logic          if_write,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    fetch_stage_if.master imem,
    output logic [31:0]   if_id_instr,
    output logic [31:0]   if_id_pc4,
    output logic          if_id_valid,
    output logic [4:0]    if_id_rs,
    output logic [4:0]    if_id_rt,
    output logic          fetch_busy
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  req_addr, addr_n;
    logic [31:0]  pc_plus4;
    logic         resp_ok;
    logic         direct;
    logic         hold_valid;

    assign pc_plus4 = pc + 32'd4;
    assign resp_ok  = (state == REQ) && imem.ready && !branch_taken;
    assign direct   = resp_ok && if_write && !hold_valid;

    assign imem.req   = (state == REQ) || (state == DROP);
    assign imem.addr  = req_addr;
    assign fetch_busy = imem.req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= addr_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = req_addr;
        unique case (state)
            IDLE: begin
                if (branch_taken) begin
                    pc_n = branch_target;
                end else if (pc_write && !hold_valid) begin
                    addr_n  = pc;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    pc_n    = branch_target;
                    state_n = imem.ready ? IDLE : DROP;
                end else if (imem.ready) begin
                    pc_n = pc_plus4;
                    // Back-to-back fetch only when IF/ID took the word.
                    if (direct && pc_write) begin
                        addr_n = pc_plus4;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DROP: begin
                if (branch_taken) pc_n = branch_target;
                if (imem.ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (branch_taken),
        .if_write   (if_write),
        .resp_valid (resp_ok),
        .resp_instr (imem.rdata),
        .resp_pc4   (pc_plus4),
        .instr      (if_id_instr),
        .pc4        (if_id_pc4),
        .valid      (if_id_valid),
        .hold_valid (hold_valid)
    );

    assign if_id_rs = if_id_instr[RS_HI:RS_LO];
    assign if_id_rt = if_id_instr[RT_HI:RT_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a program-order fetch model.
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b0;
    logic        if_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        fetch_busy;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .if_write      (if_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .fetch_busy    (fetch_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h0001_0003 + 32'h100;
    endfunction

    // Model: fptr = next address to request, exp_next = next address
    // that must appear in IF/ID; doomed = outstanding request discarded.
    logic [31:0] fptr, exp_next, prev_addr;
    logic [31:0] snap_instr, snap_pc4;
    logic        snap_valid, doomed, prev_req, prev_done;
    logic        last_branch, last_if_write;
    int          wait_left, delivered;

    task automatic model_reset();
        fptr = DEF_RESET_PC;
        exp_next = DEF_RESET_PC;
        doomed = 1'b0;
        prev_req = 1'b0;
        prev_done = 1'b0;
        prev_addr = '0;
        last_branch = 1'b0;
        last_if_write = 1'b1;
        wait_left = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem.ready = 1'b0;
        #1;
        check("rst_req", imem.req, 1'b0);
        check("rst_busy", fetch_busy, 1'b0);
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_instr", if_id_instr, DEF_NOP_INSTR);
        check("rst_pc4", if_id_pc4, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_cycle(input int mw, input bit randw);
        logic [31:0] t;
        if (last_branch) begin
            check("flush_valid", if_id_valid, 1'b0);
            check("flush_instr", if_id_instr, DEF_NOP_INSTR);
        end else if (!last_if_write) begin
            check("hold_instr", if_id_instr, snap_instr);
            check("hold_pc4", if_id_pc4, snap_pc4);
            check("hold_valid", if_id_valid, snap_valid);
        end else if (if_id_valid) begin
            check("instr", if_id_instr, mem_word(exp_next));
            check("pc4", if_id_pc4, exp_next + 32'd4);
            exp_next = exp_next + 32'd4;
            delivered++;
        end else begin
            check("bubble", if_id_instr, DEF_NOP_INSTR);
        end
        t = if_id_instr;
        check("rs", {27'b0, if_id_rs}, (t >> 21) & 32'h1f);
        check("rt", {27'b0, if_id_rt}, (t >> 16) & 32'h1f);
        check("busy", fetch_busy, imem.req);
        if (prev_req && !prev_done) check("req_held", imem.req, 1'b1);
        if (imem.req) begin
            if (!prev_req || prev_done) begin
                check("req_addr", imem.addr, fptr);
                wait_left = randw ? $urandom_range(mw, 0) : mw;
            end else begin
                check("addr_stable", imem.addr, prev_addr);
            end
        end
    endtask

    task automatic drive_commit(input int stall, input int br);
        logic done;
        pc_write = ($urandom_range(99) >= stall);
        if_write = ($urandom_range(99) >= stall);
        branch_taken = ($urandom_range(99) < br);
        case ($urandom_range(3))
            0: branch_target = 32'h40;
            1: branch_target = 32'hFFFF_FFF8;
            default: branch_target = $urandom & 32'hFFFF_FFFC;
        endcase
        if (imem.req) begin
            imem.ready = (wait_left == 0);
            if (wait_left > 0) wait_left--;
        end else begin
            imem.ready = 1'($urandom_range(1));
        end
        imem.rdata = mem_word(imem.addr);
        done = imem.req && imem.ready;
        if (done && !doomed && !branch_taken) fptr = fptr + 32'd4;
        if (done) doomed = 1'b0;
        if (branch_taken) begin
            fptr = branch_target;
            exp_next = branch_target;
            if (imem.req && !imem.ready) doomed = 1'b1;
        end
        last_branch = branch_taken;
        last_if_write = if_write;
        snap_instr = if_id_instr;
        snap_pc4 = if_id_pc4;
        snap_valid = if_id_valid;
        prev_req = imem.req;
        prev_done = done;
        prev_addr = imem.addr;
    endtask

    task automatic run_phase(input int cycles, input int mw, input bit randw,
                             input int stall, input int br, input int rst_at);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_cycle(mw, randw);
            if (i == rst_at) do_reset();
            drive_commit(stall, br);
        end
    endtask

    initial begin
        imem.ready = 1'b0;
        imem.rdata = '0;
        model_reset();
        do_reset();
        delivered = 0;
        drive_commit(0, 0);
        run_phase(40, 0, 1'b0, 0, 0, -1);
        check("zero_wait_rate", 32'(delivered >= 37), 32'd1);
        delivered = 0;
        run_phase(40, 3, 1'b0, 0, 0, -1);
        check("wait3_rate", 32'(delivered >= 8), 32'd1);
        run_phase(30, 3, 1'b0, 0, 0, 17);
        delivered = 0;
        run_phase(1500, 3, 1'b1, 25, 6, 700);
        run_phase(1500, 1, 1'b1, 40, 10, -1);
        check("progress", 32'(delivered >= 300), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the load-use hazard unit.
- Consumes the hazard unit's pc_write/if_write, produces the IF/ID instruction and its rs/rt fields.
- Owns the PC, a variable-latency instruction-memory request/ready handshake, a one-entry hold buffer for stalls, and branch flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on bubble/flush (sll $0,$0,0)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_write  in  1  1 = new fetches may issue; 0 = hazard unit freezes PC
- if_write  in  1  1 = IF/ID may update; 0 = IF/ID holds
- branch_taken  in  1  redirect/flush pulse from ID/EX
- branch_target  in  32  redirect address, valid with branch_taken
- imem_req  out  1  request to instruction memory
- imem_addr  out  32  request address, stable while imem_req=1
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  completes the current request
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_rs  out  5  if_id_instr[25:21], to hazard unit
- if_id_rt  out  5  if_id_instr[20:16], to hazard unit
- fetch_busy  out  1  1 while a request is outstanding (state REQ or DROP)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, req_addr=RESET_PC, hold_valid=0, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0. imem_req=0 and fetch_busy=0 follow from the state. Reset mid-request abandons the request with no completion required.
- imem_req = (state==REQ || state==DROP); imem_addr = req_addr, latched on every transition into REQ and held unchanged until the handshake completes.
- A handshake completes on any cycle with imem_req=1 and imem_ready=1. imem_ready in the same cycle as the request is legal (zero wait states).
- Priority: rst_n > branch_taken > normal flow.
- State IDLE:
  - branch_taken: pc<=branch_target; stay IDLE.
  - else if pc_write && !hold_valid: req_addr<=pc; go to REQ.
- State REQ:
  - branch_taken && !imem_ready: pc<=branch_target; go to DROP.
  - branch_taken && imem_ready: response discarded; pc<=branch_target; go to IDLE.
  - imem_ready (no branch): pc<=pc+4, wrapping modulo 2^32. The response is accepted directly into IF/ID if if_write && !hold_valid; otherwise it goes into the hold buffer (hold_valid<=1, with hold_instr and hold_pc4 captured).
    - If accepted directly and pc_write=1: stay in REQ with req_addr<=pc+4 (back-to-back fetch, one instruction per cycle at zero wait).
    - Otherwise: go to IDLE.
- State DROP: imem_req stays 1 until imem_ready; the response is discarded; then go to IDLE. A further branch_taken in DROP updates pc only.
- IF/ID register, evaluated each cycle:
  - branch_taken: if_id_valid<=0, if_id_instr<=NOP_INSTR, hold_valid<=0.
  - else if if_write: if hold_valid, load hold contents into IF/ID and set hold_valid<=0. Else if a direct response is accepted, load {imem_rdata, pc+4, valid=1}. Else insert a bubble (NOP_INSTR, valid=0).
  - else (if_write=0): all IF/ID fields hold.
- hold_valid=1 blocks new requests, so at most one completed instruction is ever pending. No instruction is lost or duplicated under any stall pattern.
- if_id_rs and if_id_rt are combinational slices of if_id_instr.

Decomposition:
- Shared package (mips_pkg): RESET_PC default, NOP_INSTR, state encoding (IDLE=2'd0, REQ=2'd1, DROP=2'd2), instruction field bit positions (RS_HI/LO, RT_HI/LO).
- Natural sub-module: if_id_reg, the IF/ID register with write-enable, flush, and hold-buffer load mux. The PC and FSM stay in fetch_stage.

Test Plan:
- Reset, imem_ready tied 1, pc_write=if_write=1, memory returns addr+32'h100 -> imem_addr 0,4,8,... on consecutive cycles; if_id_instr 32'h100,32'h104,...; if_id_pc4 4,8,...; if_id_valid=1 from cycle 2.
- Memory with 3 wait states -> imem_addr stable for 4 cycles per fetch; IF/ID gets bubbles (valid=0) between instructions; pc advances by 4 only on the ready cycle.
- Load-use stall: pc_write=if_write=0 for 1 cycle while a response at addr 8 arrives -> response goes to the hold buffer; IF/ID is unchanged that cycle; next cycle IF/ID = instr@8, and the next request is addr 12 with no gap or duplicate.
- branch_taken with branch_target=32'h40 during a 3-wait-state request -> state DROP; imem_req held until ready; response discarded; if_id_valid=0; next request address 32'h40.
- branch_taken on the same cycle as imem_ready with if_write=0 -> response discarded; hold_valid=0; IF/ID flushed to NOP; next fetch at branch_target.
- rst_n pulled low mid-request, then released -> all outputs at reset values immediately; first request after release is at RESET_PC.
